// File: rtl/paraadd_rr_sched.sv
// Round-robin scheduler sharing one 256-bit, 16-lane adder array among NREQ requesters.
// Credit-gated issue means the tagged result FIFO can always absorb every adder result.
module paraadd_rr_sched #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned IDW       = 2,
    parameter int unsigned ADD_LAT   = 2,
    parameter int unsigned RES_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*256-1:0]  req_a,
    input  logic [NREQ*256-1:0]  req_b,
    output logic [255:0]         add_a,
    output logic [255:0]         add_b,
    output logic                 add_v,
    input  logic [255:0]         add_res,
    input  logic                 add_res_v,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [255:0]         res_data,
    output logic [IDW-1:0]       res_id,
    output logic                 err_orphan
);

    localparam int unsigned DW   = 256;
    localparam int unsigned CNTW = $clog2(RES_DEPTH + 1);
    localparam int unsigned SUMW = CNTW + 1;

    typedef struct packed {
        logic [DW-1:0]  sum;
        logic [IDW-1:0] id;
    } res_t;

    logic [IDW-1:0]              ptr_q, ptr_d;
    logic [CNTW-1:0]             inflight_q, inflight_d;
    logic [CNTW-1:0]             count_q, count_d;
    logic                        res_valid_q, res_valid_d;
    res_t [RES_DEPTH-1:0]        fifo_q, fifo_d;
    logic [ADD_LAT:0]            tag_v_q, tag_v_d;
    logic [ADD_LAT:0][IDW-1:0]   tag_id_q, tag_id_d;
    logic [DW-1:0]               add_a_q, add_a_d;
    logic [DW-1:0]               add_b_q, add_b_d;
    logic                        add_v_q, add_v_d;
    logic                        err_orphan_q, err_orphan_d;

    logic                        can_issue_c;
    logic                        issue_c;
    logic [NREQ-1:0]             grant_c;
    logic [IDW-1:0]              gnt_idx_c;
    logic [DW-1:0]               sel_a_c, sel_b_c;
    int                          dist_c, best_c;
    logic                        push_c, pop_c;
    logic [CNTW-1:0]             wr_idx_c;

    // Arbiter: nearest valid requester after the pointer wins, provided credit remains.
    always_comb begin
        can_issue_c = (SUMW'(count_q) + SUMW'(inflight_q)) < SUMW'(RES_DEPTH);
        issue_c     = 1'b0;
        grant_c     = '0;
        gnt_idx_c   = ptr_q;
        sel_a_c     = '0;
        sel_b_c     = '0;
        dist_c      = 0;
        best_c      = int'(NREQ);
        for (int i = 0; i < int'(NREQ); i++) begin
            dist_c = (i + 2 * int'(NREQ) - int'(ptr_q) - 1) % int'(NREQ);
            if (req_valid[i] && (dist_c < best_c)) begin
                best_c    = dist_c;
                gnt_idx_c = IDW'(i);
                issue_c   = 1'b1;
            end
        end
        if (!can_issue_c || rst) begin
            issue_c = 1'b0;
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (issue_c && (gnt_idx_c == IDW'(i))) begin
                grant_c[i] = 1'b1;
                sel_a_c    = req_a[i*DW +: DW];
                sel_b_c    = req_b[i*DW +: DW];
            end
        end
    end

    // Issue register, tag pipe and credit accounting.
    always_comb begin
        ptr_d        = issue_c ? gnt_idx_c : ptr_q;
        add_v_d      = issue_c;
        add_a_d      = issue_c ? sel_a_c : add_a_q;
        add_b_d      = issue_c ? sel_b_c : add_b_q;
        tag_v_d      = {tag_v_q[ADD_LAT-1:0], issue_c};
        tag_id_d     = {tag_id_q[ADD_LAT-1:0], gnt_idx_c};
        push_c       = add_res_v && tag_v_q[ADD_LAT];
        err_orphan_d = err_orphan_q | (add_res_v & ~tag_v_q[ADD_LAT]);
        inflight_d   = inflight_q + CNTW'(issue_c) - CNTW'(push_c);
    end

    // Shifting result FIFO: entry 0 is always the head, so outputs come straight from flops.
    always_comb begin
        pop_c    = res_valid_q && res_ready;
        fifo_d   = fifo_q;
        wr_idx_c = count_q - CNTW'(pop_c);
        if (pop_c) begin
            for (int i = 0; i < int'(RES_DEPTH) - 1; i++) begin
                fifo_d[i] = fifo_q[i+1];
            end
        end
        if (push_c) begin
            for (int i = 0; i < int'(RES_DEPTH); i++) begin
                if (wr_idx_c == CNTW'(i)) begin
                    fifo_d[i].sum = add_res;
                    fifo_d[i].id  = tag_id_q[ADD_LAT];
                end
            end
        end
        count_d     = count_q + CNTW'(push_c) - CNTW'(pop_c);
        res_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= IDW'(NREQ - 1);
            inflight_q   <= '0;
            count_q      <= '0;
            res_valid_q  <= 1'b0;
            fifo_q       <= '0;
            tag_v_q      <= '0;
            tag_id_q     <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            add_v_q      <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            inflight_q   <= inflight_d;
            count_q      <= count_d;
            res_valid_q  <= res_valid_d;
            fifo_q       <= fifo_d;
            tag_v_q      <= tag_v_d;
            tag_id_q     <= tag_id_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            add_v_q      <= add_v_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign req_ready  = grant_c;
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign add_v      = add_v_q;
    assign res_valid  = res_valid_q;
    assign res_data   = fifo_q[0].sum;
    assign res_id     = fifo_q[0].id;
    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_paraadd_rr_sched.sv
// Bench for paraadd_rr_sched: lane-adder environment, transaction-level scoreboard and directed tests.
module tb_paraadd_rr_sched;

    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*256-1:0] req_a = '0;
    logic [NREQ*256-1:0] req_b = '0;
    logic [255:0]        add_a, add_b, add_res;
    logic                add_v, add_res_v;
    logic                res_valid;
    logic                res_ready = 1'b0;
    logic [255:0]        res_data;
    logic [IDW-1:0]      res_id;
    logic                err_orphan;
    logic                orphan_inj = 1'b0;

    paraadd_rr_sched #(.NREQ(NREQ), .IDW(IDW), .ADD_LAT(LAT), .RES_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .add_a(add_a), .add_b(add_b), .add_v(add_v),
        .add_res(add_res), .add_res_v(add_res_v),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
        .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] lane_add(input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        for (int l = 0; l < 16; l++) r[l*16 +: 16] = a[l*16 +: 16] + b[l*16 +: 16];
        return r;
    endfunction

    // Two-stage adder array sharing the scheduler's reset.
    logic [255:0] s1 = '0, s2 = '0;
    logic         v1 = 1'b0, v2 = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0; v2 <= 1'b0; s1 <= '0; s2 <= '0;
        end else begin
            v1 <= add_v; s1 <= lane_add(add_a, add_b);
            v2 <= v1;    s2 <= s1;
        end
    end
    assign add_res   = s2;
    assign add_res_v = v2 | orphan_inj;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Scoreboard: every issued-but-unpopped op holds one credit; results surface 4 cycles after issue.
    typedef struct {
        logic [255:0] sum;
        int           id;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0;
    int           last_gnt = NREQ - 1;
    int           n_issue = 0;
    logic         armed = 1'b0;
    logic         exp_av = 1'b0;
    logic         exp_orph = 1'b0;
    logic [255:0] last_a = '0, last_b = '0;

    always @(negedge clk) begin
        logic [NREQ-1:0] eg;
        logic            ev;
        logic            hit;
        int              gi;
        int              j;
        exp_t            e;
        eg = '0;
        gi = -1;
        if (!rst && q.size() < DEPTH) begin
            for (int k = 1; k <= NREQ; k++) begin
                j = (last_gnt + k) % NREQ;
                if (gi < 0 && req_valid[j]) gi = j;
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        ev = (q.size() > 0) && (q[0].cyc + 4 <= cyc);
        if (armed) begin
            chk("req_ready", 256'(req_ready), 256'(eg));
            chk("add_v", 256'(add_v), 256'(exp_av));
            chk("add_a", add_a, last_a);
            chk("add_b", add_b, last_b);
            chk("res_valid", 256'(res_valid), 256'(ev));
            chk("err_orphan", 256'(err_orphan), 256'(exp_orph));
            if (ev) begin
                chk("res_data", res_data, q[0].sum);
                chk("res_id", 256'(res_id), 256'(q[0].id));
            end
        end
        if (rst) begin
            q.delete();
            last_gnt = NREQ - 1;
            last_a   = '0;
            last_b   = '0;
            exp_av   = 1'b0;
            exp_orph = 1'b0;
            armed    = 1'b1;
        end else begin
            if (orphan_inj) begin
                hit = 1'b0;
                foreach (q[k]) if (q[k].cyc + 3 == cyc) hit = 1'b1;
                if (!hit) exp_orph = 1'b1;
            end
            if (ev && res_ready) void'(q.pop_front());
            exp_av = (gi >= 0);
            if (gi >= 0) begin
                e.sum = lane_add(req_a[gi*256 +: 256], req_b[gi*256 +: 256]);
                e.id  = gi;
                e.cyc = cyc;
                q.push_back(e);
                last_gnt = gi;
                last_a   = req_a[gi*256 +: 256];
                last_b   = req_b[gi*256 +: 256];
                n_issue++;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [255:0] a, input logic [255:0] b);
        req_a[i*256 +: 256] = a;
        req_b[i*256 +: 256] = b;
    endtask

    initial begin
        logic [255:0] ta, tb;
        int base;

        repeat (3) tick();
        rst = 1'b0;
        chk("reset res_valid", 256'(res_valid), 256'(0));
        chk("reset add_v", 256'(add_v), 256'(0));
        chk("reset err_orphan", 256'(err_orphan), 256'(0));
        chk("reset res_data", res_data, 256'(0));

        // Round-robin with all requesters valid.
        for (int i = 0; i < NREQ; i++) begin
            for (int l = 0; l < 16; l++) begin
                ta[l*16 +: 16] = 16'(i * 4096 + l * 17 + 1);
                tb[l*16 +: 16] = 16'(l * 257 + i);
            end
            set_op(i, ta, tb);
        end
        res_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("rr first grant", 256'(req_ready), 256'(4'b0001));
        tick();
        #1;
        chk("rr second grant", 256'(req_ready), 256'(4'b0010));
        repeat (14) tick();
        req_valid = '0;
        repeat (8) tick();

        // Single op from requester 2.
        res_ready = 1'b0;
        set_op(2, {16{16'h0001}}, {16{16'h0002}});
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick(); tick();
        chk("single early res_valid", 256'(res_valid), 256'(0));
        tick();
        chk("single res_valid", 256'(res_valid), 256'(1));
        chk("single res_data", res_data, {16{16'h0003}});
        chk("single res_id", 256'(res_id), 256'(2));
        chk("single err_orphan", 256'(err_orphan), 256'(0));
        res_ready = 1'b1;
        tick();
        chk("single drained", 256'(res_valid), 256'(0));

        // Lane wrap-around must not carry into neighbouring lanes or slices.
        set_op(1, {16{16'hFFFF}}, {16{16'h0001}});
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        repeat (3) tick();
        chk("wrap res_valid", 256'(res_valid), 256'(1));
        chk("wrap res_data", res_data, 256'(0));
        chk("wrap res_id", 256'(res_id), 256'(1));
        tick();

        // Backpressure: only the credit depth is accepted while the consumer stalls.
        res_ready = 1'b0;
        set_op(0, {16{16'h1234}}, {16{16'h0101}});
        base = n_issue;
        req_valid = 4'b0001;
        repeat (10) tick();
        chk("bp accepts", 256'(n_issue - base), 256'(4));
        chk("bp req_ready", 256'(req_ready), 256'(0));
        chk("bp head data", res_data, {16{16'h1335}});
        res_ready = 1'b1;
        repeat (12) tick();
        req_valid = '0;
        repeat (8) tick();
        chk("bp drained", 256'(res_valid), 256'(0));

        // Reset with two operations in flight.
        res_ready = 1'b0;
        set_op(3, {16{16'h00AA}}, {16{16'h0055}});
        req_valid = 4'b1000;
        tick(); tick();
        req_valid = '0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post-reset res_valid", 256'(res_valid), 256'(0));
        end

        // Orphan result with one genuine entry sitting in the FIFO.
        set_op(0, {16{16'h0010}}, {16{16'h0020}});
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        repeat (6) tick();
        chk("orphan pre res_valid", 256'(res_valid), 256'(1));
        orphan_inj = 1'b1;
        tick();
        orphan_inj = 1'b0;
        chk("orphan set", 256'(err_orphan), 256'(1));
        chk("orphan res_valid", 256'(res_valid), 256'(1));
        repeat (3) tick();
        chk("orphan sticky", 256'(err_orphan), 256'(1));
        res_ready = 1'b1;
        tick();
        chk("orphan no push", 256'(res_valid), 256'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("orphan cleared", 256'(err_orphan), 256'(0));
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
